// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Produces the packed BCD word for the multiplexed seven-segment display stage,
// saturating to all nines when the accepted value exceeds MAX_VAL.
module bin_to_bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SW    = BCD_W + BIN_W;
    localparam int CW    = $clog2(BIN_W + 1);
    localparam logic [CW-1:0]    LAST  = CW'(BIN_W - 1);
    localparam int unsigned      MAX_U = MAX_VAL;
    localparam logic [BCD_W-1:0] SAT   = {DIGITS{4'h9}};

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     scratch_next;
    logic [SW-1:0]     adjusted;
    logic [SW-1:0]     shifted;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              ovf_pend;
    logic              ovf_pend_next;
    logic              busy_next;
    logic              done_next;
    logic              overflow_next;
    logic [BCD_W-1:0]  bcd_next;

    // One double-dabble step: add 3 to every BCD nibble >= 5 (no inter-nibble carry), then shift left.
    always_comb begin
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[BIN_W + 4*d +: 4] >= 4'd5) begin
                adjusted[BIN_W + 4*d +: 4] = scratch[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        shifted = adjusted << 1;
    end

    // Next-state and output decode; the BIN_W-th shift publishes the result and returns to IDLE.
    always_comb begin
        state_next    = state;
        scratch_next  = scratch;
        cnt_next      = cnt;
        ovf_pend_next = ovf_pend;
        busy_next     = busy;
        done_next     = 1'b0;
        bcd_next      = bcd_out;
        overflow_next = overflow;
        case (state)
            IDLE: begin
                if (start) begin
                    scratch_next  = {{BCD_W{1'b0}}, bin_in};
                    cnt_next      = '0;
                    ovf_pend_next = 32'(bin_in) > MAX_U;
                    busy_next     = 1'b1;
                    state_next    = CONV;
                end
            end
            CONV: begin
                scratch_next = shifted;
                cnt_next     = cnt + 1'b1;
                if (cnt == LAST) begin
                    busy_next     = 1'b0;
                    done_next     = 1'b1;
                    overflow_next = ovf_pend;
                    bcd_next      = ovf_pend ? SAT : shifted[SW-1:BIN_W];
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            scratch  <= scratch_next;
            cnt      <= cnt_next;
            ovf_pend <= ovf_pend_next;
            busy     <= busy_next;
            done     <= done_next;
            bcd_out  <= bcd_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: expected results are queued when a
// conversion is started and checked when the done pulse appears.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   done_seen = 0;
    int   pushes = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to check fixed latency.
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check_output("overflow", 32'(overflow), 32'(e.ovf));
                check_output("latency", cyc, e.cyc);
                check_output("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic apply_stimulus(input int value, input bit expect_done);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'(value);
        if (expect_done) begin
            sb.push_back('{bcd: model_bcd(value), ovf: (value > 9999), cyc: cyc + 15});
            pushes++;
        end
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_accept", 32'(busy), 32'd1);
        check_output("done_after_accept", 32'(done), 32'd0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check_output("pending_after_wait", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_conv(input int value);
        apply_stimulus(value, 1'b1);
        wait_done();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_bcd", 32'(bcd_out), 32'd0);
        check_output("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        $display("[TB] basic conversion");
        run_conv(1234);
        repeat (3) @(negedge clk);
        check_output("bcd_hold", 32'(bcd_out), 32'h1234);
        check_output("done_low_after", 32'(done), 32'd0);

        $display("[TB] corner and saturation values");
        run_conv(0);
        run_conv(9999);
        run_conv(9);
        run_conv(10);
        run_conv(10000);
        run_conv(16383);
        run_conv(42);

        $display("[TB] busy protection");
        apply_stimulus(5678, 1'b1);
        for (int i = 2; i <= 13; i++) begin
            @(negedge clk);
            start  = (i == 5);
            bin_in = (i == 5) ? 14'd1111 : 14'($urandom_range(0, 16383));
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);

        $display("[TB] back-to-back with start held");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd321;
        sb.push_back('{bcd: model_bcd(321), ovf: 1'b0, cyc: cyc + 15});
        pushes++;
        repeat (15) @(negedge clk);
        bin_in = 14'd654;
        sb.push_back('{bcd: model_bcd(654), ovf: 1'b0, cyc: cyc + 15});
        pushes++;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        $display("[TB] reset mid-conversion");
        apply_stimulus(8888, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_bcd", 32'(bcd_out), 32'd0);
        check_output("abort_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_output("abort_no_done_bcd", 32'(bcd_out), 32'd0);
        run_conv(77);

        check_output("done_count", done_seen, pushes);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
